// File: rtl/aoc_pkg.sv
// Shared types and constants for the puzzle-input streamer.
// Holds the streamer state enum and the ASCII range helpers.
package aoc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT,
    S_DONE,
    S_ERROR
  } stream_state_t;

  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_MIN = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h7E;

  function automatic logic is_legal(input logic [7:0] b);
    return (b == ASCII_LF) ||
           ((b >= ASCII_MIN) && (b <= ASCII_MAX));
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry shift FIFO of {last, data}.
// Entry 0 is the head, so the outputs come straight from flops.
module stream_fifo2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  logic [8:0] din,
  input  logic       pop,
  output logic [8:0] dout,
  output logic       full,
  output logic       empty
);

  logic       v0;
  logic       v1;
  logic [8:0] d0;
  logic [8:0] d1;

  assign dout  = d0;
  assign full  = v1;
  assign empty = ~v0;

  // Shift toward the head on pop, fill the first free slot on push.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      d0 <= '0;
      d1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!v0) begin
            d0 <= din;
            v0 <= 1'b1;
          end else begin
            d1 <= din;
            v1 <= 1'b1;
          end
        end
        2'b01: begin
          d0 <= d1;
          v0 <= v1;
          v1 <= 1'b0;
        end
        2'b11: begin
          if (v1) begin
            d0 <= d1;
            d1 <= din;
          end else begin
            d0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/input_streamer.sv
// Streams a ROM-held puzzle input to a solver over valid/ready.
// Checks every byte, watches for an early or late solver finish.
module input_streamer
  import aoc_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LENGTH  = 100,
  parameter int TIMEOUT = 1024
) (
  input  logic              Clk,
  input  logic              Rstn,
  input  logic              Start,
  output logic [ADDR_W-1:0] RomAddr,
  input  logic [7:0]        RomData,
  output logic              OutValid,
  output logic [7:0]        OutData,
  output logic              OutLast,
  input  logic              OutReady,
  input  logic              SolverDone,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] LEN  = (ADDR_W+1)'(LENGTH);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(LENGTH - 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  stream_state_t   state;
  stream_state_t   state_n;
  logic [ADDR_W:0] nxt;
  logic            inflight;
  logic            inflight_last;
  logic [WD_W-1:0] wd;
  logic            rd_en;
  logic            push;
  logic            pop;
  logic            clr;
  logic            full;
  logic            empty;
  logic            byte_bad;
  logic [1:0]      occ;
  logic [2:0]      load;
  logic [8:0]      head;

  // A read may issue only if the byte it returns is sure to fit,
  // counting the slot freed by a pop this cycle.
  assign pop      = OutValid & OutReady;
  assign occ      = full ? 2'd2 : (empty ? 2'd0 : 2'd1);
  assign load     = {1'b0, occ} + {2'b0, inflight};
  assign rd_en    = (state == S_STREAM) && (nxt < LEN) &&
                    (load < (3'd2 + {2'b0, pop}));
  assign byte_bad = inflight && !is_legal(RomData);
  assign push     = inflight && (state == S_STREAM) && !byte_bad;
  assign clr      = (state_n == S_ERROR);

  assign RomAddr  = rd_en ? nxt[ADDR_W-1:0] : '0;
  assign OutValid = ~empty;
  assign OutData  = head[7:0];
  assign OutLast  = head[8];
  assign Busy     = (state == S_STREAM) || (state == S_WAIT);
  assign Done     = (state == S_DONE);
  assign Error    = (state == S_ERROR);

  stream_fifo2 u_fifo (
    .clk   (Clk),
    .rst_n (Rstn),
    .clr   (clr),
    .push  (push),
    .din   ({inflight_last, RomData}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // State register, read pointer, in-flight tracking and watchdog.
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      state         <= S_IDLE;
      nxt           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wd            <= '0;
    end else begin
      state         <= state_n;
      inflight      <= rd_en;
      inflight_last <= rd_en && (nxt == LAST);
      if (rd_en) nxt <= nxt + (ADDR_W+1)'(1);
      wd <= (state == S_WAIT) ? wd + WD_W'(1) : '0;
    end
  end

  // Next-state: a bad byte or an early finish aborts the stream;
  // a finish on the last watchdog cycle still counts as success.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (Start) state_n = S_STREAM;
      end
      S_STREAM: begin
        if (byte_bad || SolverDone) state_n = S_ERROR;
        else if (pop && OutLast)    state_n = S_WAIT;
      end
      S_WAIT: begin
        if (SolverDone)        state_n = S_DONE;
        else if (wd == WD_MAX) state_n = S_ERROR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_input_streamer.sv
// Directed bench for input_streamer with a byte scoreboard.
// Covers latency, backpressure, watchdog, bad byte and reset.
module tb_input_streamer;

  localparam int LEN = 4;
  localparam int TO  = 12;

  logic        Clk = 1'b0;
  logic        Rstn = 1'b0;
  logic        Start = 1'b0;
  logic        OutReady = 1'b0;
  logic        SolverDone = 1'b0;
  logic [15:0] RomAddr;
  logic [7:0]  RomData;
  logic        OutValid;
  logic [7:0]  OutData;
  logic        OutLast;
  logic        Busy;
  logic        Done;
  logic        Error;

  logic [7:0]  rom [16];
  logic [8:0]  exp_q [$];
  int          checks = 0;
  int          errors = 0;
  logic        stall_q = 1'b0;
  logic [8:0]  held = '0;

  input_streamer #(
    .ADDR_W  (16),
    .LENGTH  (LEN),
    .TIMEOUT (TO)
  ) dut (
    .Clk        (Clk),
    .Rstn       (Rstn),
    .Start      (Start),
    .RomAddr    (RomAddr),
    .RomData    (RomData),
    .OutValid   (OutValid),
    .OutData    (OutData),
    .OutLast    (OutLast),
    .OutReady   (OutReady),
    .SolverDone (SolverDone),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) RomData <= rom[RomAddr[3:0]];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge Clk) begin
    if (Rstn) begin
      if (stall_q) begin
        check("stall_valid", OutValid, 1);
        check("stall_data", {OutLast, OutData}, held);
      end
      if (OutValid && OutReady) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check("sb_byte", {OutLast, OutData}, exp_q.pop_front());
      end
      stall_q <= OutValid && !OutReady;
      held    <= {OutLast, OutData};
    end else begin
      stall_q <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rstn = 1'b0;
    Start = 1'b0;
    SolverDone = 1'b0;
    tick();
    Rstn = 1'b1;
  endtask

  task automatic check_reset();
    check("rst_addr", RomAddr, 0);
    check("rst_valid", OutValid, 0);
    check("rst_data", OutData, 0);
    check("rst_last", OutLast, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_error", Error, 0);
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({i == LEN - 1, rom[i]});
  endtask

  task automatic stream4();
    push_exp(LEN);
    Start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        Start = 1'b0;
        check("busy_stream", Busy, 1);
      end
      check($sformatf("valid_t%0d", k), OutValid, k >= 3);
      check($sformatf("last_t%0d", k), OutLast, k == 6);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h31;
    rom[1] = 8'h32;
    rom[2] = 8'h0A;
    rom[3] = 8'h33;
    OutReady = 1'b1;
    Rstn = 1'b0;
    tick();
    tick();
    Rstn = 1'b1;
    check_reset();

    SolverDone = 1'b1;
    tick();
    SolverDone = 1'b0;
    tick();
    check("idle_sd_busy", Busy, 0);
    check("idle_sd_done", Done, 0);
    check("idle_sd_error", Error, 0);

    stream4();
    tick();
    check("wait_busy", Busy, 1);
    check("wait_done", Done, 0);
    repeat (9) tick();
    SolverDone = 1'b1;
    tick();
    SolverDone = 1'b0;
    check("sd10_done", Done, 1);
    check("sd10_busy", Busy, 0);
    check("sd10_error", Error, 0);

    Start = 1'b1;
    SolverDone = 1'b1;
    tick();
    Start = 1'b0;
    SolverDone = 1'b0;
    tick();
    check("done_hold_done", Done, 1);
    check("done_hold_busy", Busy, 0);
    check("done_hold_error", Error, 0);
    check("done_hold_valid", OutValid, 0);
    check("sb_drain_basic", exp_q.size(), 0);

    do_reset();
    stream4();
    repeat (TO) tick();
    check("to_pre_error", Error, 0);
    check("to_pre_busy", Busy, 1);
    tick();
    check("to_error", Error, 1);
    check("to_done", Done, 0);
    check("to_busy", Busy, 0);
    check("to_valid", OutValid, 0);

    do_reset();
    stream4();
    repeat (TO) tick();
    SolverDone = 1'b1;
    tick();
    SolverDone = 1'b0;
    check("to_win_done", Done, 1);
    check("to_win_error", Error, 0);

    do_reset();
    push_exp(LEN);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
      OutReady = (k % 3 == 0);
      tick();
    end
    check("bp_drain", exp_q.size(), 0);
    OutReady = 1'b1;
    tick();
    check("bp_wait_busy", Busy, 1);

    do_reset();
    push_exp(LEN);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    Rstn = 1'b0;
    tick();
    Rstn = 1'b1;
    check_reset();
    check("rst_consumed", exp_q.size(), 2);
    exp_q.delete();
    stream4();
    tick();
    check("rst_restart_drain", exp_q.size(), 0);

    do_reset();
    rom[2] = 8'h07;
    push_exp(2);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    check("bad_v1", OutValid, 1);
    tick();
    check("bad_error", Error, 1);
    check("bad_done", Done, 0);
    check("bad_valid", OutValid, 0);
    check("bad_busy", Busy, 0);
    repeat (3) tick();
    check("bad_drain", exp_q.size(), 0);
    check("bad_sticky", Error, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
